// File: rtl/scroll_window.sv
// Scrolling window over a circular sequence of symbol indices.
// A prescaler paces the steps, and the block supports direction, hold, one-shot stop and position load.
module scroll_window #(
    parameter int  DIGITS   = 4,
    parameter int  SYM_W    = 4,
    parameter int  MSG_LEN  = 16,
    parameter int  PRESCALE = 1,
    localparam int PW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    oneshot,
    input  logic                    load,
    input  logic [PW-1:0]           load_pos,
    output logic [DIGITS*SYM_W-1:0] display,
    output logic [PW-1:0]           pos,
    output logic                    tick,
    output logic                    done
);

    localparam int              PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [PW:0]     LEN_EXT  = (PW+1)'(MSG_LEN);
    localparam logic [PSW-1:0]  PRE_LAST = PSW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [PW-1:0]  r_pos;
    logic [PSW-1:0] r_presc;
    logic           r_tick;
    logic           r_done;

    logic [PW-1:0]  w_pos_next;
    logic [PW-1:0]  w_pos_end;
    logic           w_load_ok;

    always_comb begin
        if (dir) begin
            w_pos_next = (r_pos == '0) ? POS_LAST : r_pos - PW'(1);
        end else begin
            w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
        end
    end

    assign w_pos_end = dir ? '0 : POS_LAST;
    assign w_load_ok = ({1'b0, load_pos} < LEN_EXT);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pos   <= '0;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else if (load) begin
            if (w_load_ok) begin
                r_pos <= load_pos;
            end
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= en ? S_RUN : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tick <= 1'b0;
                    if (en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        // Prescaler is kept so a resume continues mid-count.
                        r_tick  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_presc == PRE_LAST) begin
                        r_presc <= '0;
                        r_pos   <= w_pos_next;
                        r_tick  <= 1'b1;
                        if (oneshot && (w_pos_next == w_pos_end)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PSW'(1);
                        r_tick  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_tick <= 1'b0;
                    if (!en) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // pos < MSG_LEN and k < MSG_LEN, so a single conditional subtract gives the modulo.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [PW:0] w_sum;
        logic [PW:0] w_idx;
        assign w_sum = {1'b0, r_pos} + (PW+1)'(k);
        assign w_idx = (w_sum >= LEN_EXT) ? (w_sum - LEN_EXT) : w_sum;
        assign display[(DIGITS-k)*SYM_W-1 -: SYM_W] = SYM_W'(w_idx);
    end

    assign pos  = r_pos;
    assign tick = r_tick;
    assign done = r_done;

endmodule

// File: tb/tb_scroll_window.sv
// Scoreboard bench for scroll_window: directed stimulus pushes expected ticks, monitors compare.
// Two instances: 4 digits / 16 symbols / prescale 3, and 6 digits / 10 symbols / prescale 1.
module tb_scroll_window;

    typedef struct {
        int          cyc;
        int          pos;
        logic [23:0] disp;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    logic        a_en, a_dir, a_oneshot, a_load;
    logic [3:0]  a_load_pos;
    logic [15:0] a_display;
    logic [3:0]  a_pos;
    logic        a_tick, a_done;

    logic        b_en, b_dir, b_oneshot, b_load;
    logic [3:0]  b_load_pos;
    logic [23:0] b_display;
    logic [3:0]  b_pos;
    logic        b_tick, b_done;

    scroll_window #(.DIGITS(4), .SYM_W(4), .MSG_LEN(16), .PRESCALE(3)) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .dir(a_dir), .oneshot(a_oneshot),
        .load(a_load), .load_pos(a_load_pos), .display(a_display), .pos(a_pos),
        .tick(a_tick), .done(a_done)
    );

    scroll_window #(.DIGITS(6), .SYM_W(4), .MSG_LEN(10), .PRESCALE(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .dir(b_dir), .oneshot(b_oneshot),
        .load(b_load), .load_pos(b_load_pos), .display(b_display), .pos(b_pos),
        .tick(b_tick), .done(b_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [23:0] exp_disp(input int p, input int digits, input int len);
        logic [23:0] r = '0;
        for (int k = 0; k < digits; k++) r = (r << 4) | 24'((p + k) % len);
        return r;
    endfunction

    task automatic push_a(input int c, input int p, input logic [23:0] d, input logic dn);
        exp_t e;
        e.cyc = c; e.pos = p; e.disp = d; e.done = dn;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int p, input logic [23:0] d);
        exp_t e;
        e.cyc = c; e.pos = p; e.disp = d; e.done = 1'b0;
        qb.push_back(e);
    endtask

    task automatic drain_a(input int budget);
        int k = 0;
        while (qa.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("a_drain_pending", qa.size(), 0);
        qa.delete();
    endtask

    always begin : mon_a
        exp_t e;
        @(posedge clk);
        #1;
        if (a_tick) begin
            if (qa.size() == 0) begin
                check("a_unexpected_tick_pos", a_pos, 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                check("a_tick_cycle", cyc, e.cyc);
                check("a_tick_pos", a_pos, e.pos);
                check("a_tick_display", a_display, e.disp);
                check("a_tick_done", a_done, e.done);
            end
        end
    end

    always begin : mon_b
        exp_t e;
        @(posedge clk);
        #1;
        if (b_tick) begin
            if (qb.size() == 0) begin
                check("b_unexpected_tick_pos", b_pos, 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                check("b_tick_cycle", cyc, e.cyc);
                check("b_tick_pos", b_pos, e.pos);
                check("b_tick_display", b_display, e.disp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_en = 0; a_dir = 0; a_oneshot = 0; a_load = 0; a_load_pos = '0;
        b_en = 0; b_dir = 0; b_oneshot = 0; b_load = 0; b_load_pos = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_a_display", a_display, 16'h0123);
        check("rst_a_pos", a_pos, 0);
        check("rst_a_tick", a_tick, 0);
        check("rst_a_done", a_done, 0);
        check("rst_b_display", b_display, 24'h012345);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Forward scroll through a full wrap, one tick every 3 cycles
        a_en = 1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 13)      push_a(cyc + 1 + 3*k, 13, 24'hDEF0, 0);
            else if (k == 16) push_a(cyc + 1 + 3*k, 0, 24'h0123, 0);
            else              push_a(cyc + 1 + 3*k, k, exp_disp(k, 4, 16), 0);
        end
        drain_a(80);

        // Backward from 0 wraps to 15
        a_dir = 1;
        push_a(cyc + 3, 15, 24'hF012, 0);
        drain_a(10);

        // Hold with prescaler at 2, then resume mid-count
        @(negedge clk);
        @(negedge clk);
        a_en = 0;
        repeat (5) @(negedge clk);
        check("hold_pos", a_pos, 15);
        a_en = 1;
        push_a(cyc + 2, 14, 24'hEF01, 0);
        drain_a(10);

        // Load during RUN with prescaler at 1
        a_dir = 0;
        @(negedge clk);
        a_load = 1; a_load_pos = 4'd9;
        @(negedge clk);
        a_load = 0;
        check("load_pos", a_pos, 9);
        check("load_no_tick", a_tick, 0);
        push_a(cyc + 3, 10, 24'hABCD, 0);
        drain_a(10);

        // One-shot forward stops at 15
        a_load = 1; a_load_pos = 4'd12; a_oneshot = 1;
        @(negedge clk);
        a_load = 0;
        check("oneshot_load_pos", a_pos, 12);
        push_a(cyc + 3, 13, 24'hDEF0, 0);
        push_a(cyc + 6, 14, 24'hEF01, 0);
        push_a(cyc + 9, 15, 24'hF012, 1);
        drain_a(20);
        repeat (22) @(negedge clk);
        check("done_hold_pos", a_pos, 15);
        check("done_hold_display", a_display, 16'hF012);
        check("done_hold_done", a_done, 1);
        a_en = 0;
        @(negedge clk);
        check("done_cleared", a_done, 0);

        // A step starting at the end position wraps even in one-shot mode
        a_en = 1;
        push_a(cyc + 4, 0, 24'h0123, 0);
        drain_a(10);
        a_en = 0; a_oneshot = 0;
        @(negedge clk);

        // Reset between edges during RUN
        a_en = 1; a_load = 1; a_load_pos = 4'd5;
        @(negedge clk);
        a_load = 0;
        @(negedge clk);
        check("prereset_pos", a_pos, 5);
        rst = 1'b0;
        #1;
        check("midrun_rst_pos", a_pos, 0);
        check("midrun_rst_display", a_display, 16'h0123);
        check("midrun_rst_tick", a_tick, 0);
        check("midrun_rst_done", a_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_a(cyc + 4, 1, 24'h1234, 0);
        drain_a(10);
        a_en = 0;
        @(negedge clk);

        // Six digits over ten symbols, stepping every cycle across the wrap
        b_load = 1; b_load_pos = 4'd7; b_en = 1;
        @(negedge clk);
        b_load = 0;
        check("b_load_pos", b_pos, 7);
        check("b_load_display", b_display, 24'h789012);
        push_b(cyc + 1, 8, 24'h890123);
        push_b(cyc + 2, 9, 24'h901234);
        push_b(cyc + 3, 0, 24'h012345);
        push_b(cyc + 4, 1, 24'h123456);
        push_b(cyc + 5, 2, 24'h234567);
        repeat (5) @(negedge clk);
        b_load = 1; b_load_pos = 4'd12;
        @(negedge clk);
        b_load = 0; b_en = 0;
        check("b_bad_load_pos", b_pos, 2);
        check("b_bad_load_tick", b_tick, 0);
        check("b_bad_load_display", b_display, 24'h234567);
        repeat (3) @(negedge clk);
        check("b_idle_pos", b_pos, 2);
        check("b_queue_empty", qb.size(), 0);
        check("a_queue_empty", qa.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scroll_window.md
Name: scroll_window

Overview:
- Parameterised successor to the fixed 4-digit scroller.
- Steps a DIGITS-wide window over a circular sequence of MSG_LEN symbol indices, one step per PRESCALE enabled clocks.
- Adds direction, enable/hold, one-shot mode, position load, tick and done outputs.
- Output feeds the per-digit converter/display driver. Each digit field is a raw symbol index; the downstream converter does the encoding.

Parameters:
- DIGITS, 4, number of window digits; must be ≥1 and ≤ MSG_LEN.
- SYM_W, 4, bits per digit field; MSG_LEN ≤ 2^SYM_W.
- MSG_LEN, 16, sequence length; positions are 0..MSG_LEN-1.
- PRESCALE, 1, enabled clocks per step; must be ≥1. With 1, the block steps every cycle.
- PW, clog2(MSG_LEN) (min 1), width of pos and load_pos; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  1 = scroll; 0 = hold.
- dir  in  1  0 = forward (pos+1); 1 = backward (pos-1).
- oneshot  in  1  1 = stop at end of sequence; 0 = wrap forever.
- load  in  1  synchronous load of load_pos.
- load_pos  in  PW  new position.
- display  out  DIGITS*SYM_W  window; digit k (k=0 leftmost) at bits [(DIGITS-k)*SYM_W-1 -: SYM_W].
- pos  out  PW  current window start.
- tick  out  1  one-cycle pulse marking a step.
- done  out  1  one-shot end reached.

Behaviour:
- Reset (rst=0, no clock needed): state IDLE, pos=0, prescaler=0, tick=0, done=0, display={0,1,..,DIGITS-1}.
- display is combinational from pos. Digit k = (pos+k) mod MSG_LEN, zero-extended to SYM_W.
- States:
  - IDLE: prescaler frozen. en=1 -> RUN.
  - RUN:
    - Prescaler counts 0..PRESCALE-1 each cycle.
    - At PRESCALE-1 the prescaler wraps to 0 and pos steps by ±1 mod MSG_LEN, per dir sampled that cycle.
    - Forward 0..MSG_LEN-1 wraps to 0; backward 0 wraps to MSG_LEN-1.
    - en=0 -> IDLE with no step, even if the prescaler is at PRESCALE-1. The prescaler value is kept, so resume continues mid-count.
  - DONE: pos and prescaler frozen, done=1, no ticks. en=0 -> IDLE and done clears the same edge.
- tick:
  - Registered; high exactly in the cycle after the stepping edge.
  - That is the first cycle pos/display show the new value.
  - Latency: en rising in IDLE with prescaler=0 gives the first tick PRESCALE+1 cycles after en is sampled.
- One-shot:
  - If oneshot=1 when a step lands on the end position, the state goes to DONE on that edge.
  - End position is MSG_LEN-1 for forward, 0 for backward.
  - tick still pulses for that final step; done=1 from the same cycle.
  - A step that starts already at the end position wraps normally.
  - oneshot=0 never enters DONE.
- load (priority over en/step, below reset):
  - load_pos < MSG_LEN: pos <= load_pos.
  - load_pos ≥ MSG_LEN: pos unchanged.
  - In all cases: prescaler <= 0, done <= 0, tick <= 0, state <= RUN if en=1 else IDLE.
  - No step occurs on a load edge.
- dir or oneshot changes take effect at the next step; no other side effects.
- Reset mid-operation aborts immediately to reset values. Release is synchronous-safe; the first active edge after release obeys IDLE rules.

Test Plan:
1. Reset: defaults, hold rst=0 -> display=0x0123, pos=0, tick=0, done=0. Pull rst low mid-RUN between edges -> outputs return to reset values before the next edge.
2. Forward wrap: PRESCALE=3, en=1, dir=0 -> tick every 3rd cycle; after 13 ticks display=0xDEF0; after 16 ticks pos=0, display=0x0123.
3. Backward and hold:
   - dir=1 from pos=0 -> next tick pos=15, display=0xF012.
   - Drop en on the cycle the prescaler=2 -> no step, IDLE.
   - Raise en -> the step lands exactly 1 cycle after the resume edge.
4. One-shot: load_pos=12, oneshot=1, en=1, dir=0 -> ticks to 13, 14, 15; done=1 with the 3rd tick; pos stays 15 and display=0xF012 for 20+ cycles with no tick; en=0 -> done=0, IDLE.
5. Load: during RUN with prescaler=1, load=1, load_pos=9 -> pos=9 next cycle, no tick; next tick exactly PRESCALE cycles later gives pos=10.
6. Generic: DIGITS=6, MSG_LEN=10, PRESCALE=1 -> display each cycle matches (pos+k) mod 10 across the wrap (pos=7 -> 7,8,9,0,1,2); load_pos=12 is ignored and pos is unchanged.
